// File: rtl/stk_pipe_al_init_mb.sv
// Multi-bank memory initialiser: walks every line of each enabled bank, issuing per-bank
// write requests that hold until granted, filling with identity or linked-list data.
module stk_pipe_al_init_mb #(
    parameter int unsigned BANKS_N = 2,
    parameter int unsigned LINES_N = 256,
    parameter int unsigned MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_init,
    input  logic [BANKS_N-1:0]         i_bank_en,
    input  logic [BANKS_N-1:0]         i_wr_rdy,
    output logic [BANKS_N-1:0]         o_init_wen_r,
    output logic [$clog2(LINES_N)-1:0] o_init_waddr_r,
    output logic [$clog2(LINES_N)-1:0] o_init_wdata_r,
    output logic                       o_busy_r,
    output logic                       o_done_r
);

    localparam int unsigned LINE_W = $clog2(LINES_N);
    localparam logic [LINE_W-1:0] ADDR_LAST = LINE_W'(LINES_N - 1);

    typedef enum logic [1:0] {StIdle, StPrep, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [BANKS_N-1:0]  mask_q, mask_d;
    logic [BANKS_N-1:0]  pend_q, pend_d;
    logic [BANKS_N-1:0]  pend_left;
    logic [LINE_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // pend_q doubles as the write-enable output, so it is kept zero outside BUSY.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pend_left = pend_q & ~i_wr_rdy;

        if (i_init) begin
            state_d = StPrep;
            mask_d  = i_bank_en;
            pend_d  = '0;
            addr_d  = '0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pend_d = '0;
                    busy_d = 1'b0;
                end
                StPrep: begin
                    addr_d = '0;
                    pend_d = mask_q;
                    if (mask_q != '0) begin
                        state_d = StBusy;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                StBusy: begin
                    if (pend_left != '0) begin
                        pend_d = pend_left;
                    end else if (addr_q != ADDR_LAST) begin
                        addr_d = addr_q + LINE_W'(1);
                        pend_d = mask_q;
                    end else begin
                        state_d = StDone;
                        pend_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    pend_d  = '0;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    pend_d  = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // Linked-list fill points each line at its successor; the last line wraps to 0.
        data_d = (MODE == 1) ? addr_d + LINE_W'(1) : addr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_init_wen_r   = pend_q;
    assign o_init_waddr_r = addr_q;
    assign o_init_wdata_r = data_q;
    assign o_busy_r       = busy_q;
    assign o_done_r       = done_q;

endmodule

// File: tb/tb_stk_pipe_al_init_mb.sv
// Scoreboard bench: two instances (identity and linked-list fill) share stimulus; every
// write or done presentation is popped from an expected queue and compared.
module tb_stk_pipe_al_init_mb;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_init;
    logic [1:0] i_bank_en;
    logic [1:0] i_wr_rdy;
    logic [1:0] wen0, wen1;
    logic [2:0] addr0, addr1, data0, data1;
    logic       busy0, busy1, done0, done1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] wen;
        logic [2:0] addr;
        logic       done;
    } exp_t;
    exp_t exp_q[$];

    stk_pipe_al_init_mb #(.BANKS_N(2), .LINES_N(8), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_init(i_init), .i_bank_en(i_bank_en), .i_wr_rdy(i_wr_rdy),
        .o_init_wen_r(wen0), .o_init_waddr_r(addr0), .o_init_wdata_r(data0),
        .o_busy_r(busy0), .o_done_r(done0)
    );

    stk_pipe_al_init_mb #(.BANKS_N(2), .LINES_N(8), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_init(i_init), .i_bank_en(i_bank_en), .i_wr_rdy(i_wr_rdy),
        .o_init_wen_r(wen1), .o_init_waddr_r(addr1), .o_init_wdata_r(data1),
        .o_busy_r(busy1), .o_done_r(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [1:0] w, input int a, input logic d);
        exp_t e;
        e.cyc  = c;
        e.wen  = w;
        e.addr = a[2:0];
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_wen0"}, wen0, 0);
        check({name, "_wen1"}, wen1, 0);
        check({name, "_busy0"}, busy0, 0);
        check({name, "_busy1"}, busy1, 0);
        check({name, "_done0"}, done0, 0);
    endtask

    // Monitor: any write request or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en && (wen0 != 2'b00 || wen1 != 2'b00 || done0 || done1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: wen0=%b wen1=%b done0=%b done1=%b at cycle %0d, none expected",
                         wen0, wen1, done0, done1, cyc);
            end else begin
                exp_t e;
                logic [2:0] nxt;
                e   = exp_q.pop_front();
                nxt = e.addr + 3'd1;
                check("cycle", cyc, e.cyc);
                check("wen_mode0", wen0, e.wen);
                check("wen_mode1", wen1, e.wen);
                check("done_mode0", done0, e.done);
                check("done_mode1", done1, e.done);
                if (e.wen != 2'b00) begin
                    check("addr_mode0", addr0, e.addr);
                    check("addr_mode1", addr1, e.addr);
                    check("data_mode0", data0, e.addr);
                    check("data_mode1", data1, nxt);
                end
            end
        end
    end

    initial begin
        int c0;
        rst       = 1'b1;
        i_init    = 1'b0;
        i_bank_en = 2'b00;
        i_wr_rdy  = 2'b11;
        step();
        step();
        check_quiet("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // Full fill, all grants high: PREP at +1, writes +2..+9, done at +10.
        c0 = cyc;
        for (int a = 0; a < 8; a++) push(c0 + 2 + a, 2'b11, a, 1'b0);
        push(c0 + 10, 2'b00, 0, 1'b1);
        i_init = 1'b1; i_bank_en = 2'b11; i_wr_rdy = 2'b11;
        step();
        i_init = 1'b0;
        check("prep_busy", busy0, 1);
        check("prep_wen", wen0, 0);
        repeat (11) step();
        check("idle_after_done", busy0, 0);

        // Bank 0 only, grant withheld for two cycles at addr 3; bank_en change is ignored.
        c0 = cyc;
        for (int a = 0; a < 3; a++) push(c0 + 2 + a, 2'b01, a, 1'b0);
        for (int k = 0; k < 3; k++) push(c0 + 5 + k, 2'b01, 3, 1'b0);
        for (int a = 4; a < 8; a++) push(c0 + 4 + a, 2'b01, a, 1'b0);
        push(c0 + 12, 2'b00, 0, 1'b1);
        i_init = 1'b1; i_bank_en = 2'b01; i_wr_rdy = 2'b11;
        for (int k = 1; k <= 14; k++) begin
            step();
            i_init    = 1'b0;
            i_bank_en = 2'b11;
            if (k == 5) i_wr_rdy = 2'b10;
            if (k == 7) i_wr_rdy = 2'b11;
        end

        // Split grant at addr 2: bank 0 first, then bank 1.
        c0 = cyc;
        for (int a = 0; a < 3; a++) push(c0 + 2 + a, 2'b11, a, 1'b0);
        push(c0 + 5, 2'b10, 2, 1'b0);
        for (int a = 3; a < 8; a++) push(c0 + 3 + a, 2'b11, a, 1'b0);
        push(c0 + 11, 2'b00, 0, 1'b1);
        i_init = 1'b1; i_bank_en = 2'b11; i_wr_rdy = 2'b11;
        for (int k = 1; k <= 13; k++) begin
            step();
            i_init = 1'b0;
            if (k == 4) i_wr_rdy = 2'b01;
            if (k == 5) i_wr_rdy = 2'b10;
            if (k == 6) i_wr_rdy = 2'b11;
        end

        // Restart at addr 5 onto bank 1 only; a single done pulse at the very end.
        c0 = cyc;
        for (int a = 0; a < 6; a++) push(c0 + 2 + a, 2'b11, a, 1'b0);
        for (int a = 0; a < 8; a++) push(c0 + 9 + a, 2'b10, a, 1'b0);
        push(c0 + 17, 2'b00, 0, 1'b1);
        i_init = 1'b1; i_bank_en = 2'b11; i_wr_rdy = 2'b11;
        for (int k = 1; k <= 19; k++) begin
            step();
            i_init = 1'b0;
            if (k == 7) begin
                i_init    = 1'b1;
                i_bank_en = 2'b10;
            end
            if (k == 8) check("restart_prep_wen", wen0, 0);
        end

        // Empty mask: PREP then DONE straight away.
        c0 = cyc;
        push(c0 + 2, 2'b00, 0, 1'b1);
        i_init = 1'b1; i_bank_en = 2'b00;
        step();
        i_init = 1'b0;
        check("empty_prep_busy", busy1, 1);
        repeat (3) step();

        // Reset at addr 4 abandons the sequence with no done pulse.
        c0 = cyc;
        for (int a = 0; a < 5; a++) push(c0 + 2 + a, 2'b11, a, 1'b0);
        i_init = 1'b1; i_bank_en = 2'b11; i_wr_rdy = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            step();
            i_init = 1'b0;
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                check_quiet("mid_reset");
                rst = 1'b0;
            end
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
